// File: rtl/rob_pkg.sv
// Shared ROB definitions: PC width, commit-controller state encoding and ROB entry layout.
package rob_pkg;

    localparam int unsigned PC_W = 16;

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StFlush   = 2'd1,
        StRecover = 2'd2
    } state_e;

    // Bit offsets of the fields inside a packed ROB entry
    localparam int unsigned ROB_DONE_BIT    = 0;
    localparam int unsigned ROB_MISPRED_BIT = 1;
    localparam int unsigned ROB_STORE_BIT   = 2;
    localparam int unsigned ROB_BUSY_BIT    = 3;
    localparam int unsigned ROB_PC_LSB      = 4;
    localparam int unsigned ROB_ENTRY_W     = ROB_PC_LSB + PC_W;

endpackage

// File: rtl/rob_retire_select.sv
// Combinational grant logic for the two oldest ROB entries: retire enables, store commit,
// and mispredict detection on the youngest retiring entry.
module rob_retire_select
    import rob_pkg::*;
#(
    parameter int unsigned PC_W = rob_pkg::PC_W
) (
    input  logic            run_i,
    input  logic            h1_v_i,
    input  logic            h1_done_i,
    input  logic            h1_mispred_i,
    input  logic [PC_W-1:0] h1_new_pc_i,
    input  logic            h1_store_i,
    input  logic            h2_v_i,
    input  logic            h2_done_i,
    input  logic            h2_mispred_i,
    input  logic [PC_W-1:0] h2_new_pc_i,
    input  logic            h2_store_i,
    input  logic            sb_ready_i,
    output logic            retire1_o,
    output logic            retire2_o,
    output logic            sb_commit_o,
    output logic            mispred_o,
    output logic [PC_W-1:0] target_o
);

    logic ok1;
    logic slot1_mispred;

    always_comb begin
        ok1 = h1_v_i & h1_done_i & (~h1_store_i | sb_ready_i);
        retire1_o = run_i & ok1;
        // Slot 2 only follows slot 1, never past a mispredict, and never as a second store
        retire2_o = retire1_o & ~h1_mispred_i & h2_v_i & h2_done_i
                  & ~(h1_store_i & h2_store_i) & (~h2_store_i | sb_ready_i);
        sb_commit_o = (retire1_o & h1_store_i) | (retire2_o & h2_store_i);
        slot1_mispred = retire1_o & h1_mispred_i;
        mispred_o = (retire2_o & h2_mispred_i) | slot1_mispred;
        target_o = slot1_mispred ? h1_new_pc_i : h2_new_pc_i;
    end

endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB commit sequencer: dual in-order retirement plus the flush/redirect/recovery sequence
// that follows retirement of a mispredicted branch.
module rob_commit_ctrl
    import rob_pkg::*;
#(
    parameter int unsigned PC_W           = rob_pkg::PC_W,
    parameter int unsigned RECOVER_CYCLES = 2,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Head1_V,
    input  logic             Head1_Done,
    input  logic             Head1_Mispred,
    input  logic [PC_W-1:0]  Head1_NewPC,
    input  logic             Head1_IsStore,
    input  logic             Head2_V,
    input  logic             Head2_Done,
    input  logic             Head2_Mispred,
    input  logic [PC_W-1:0]  Head2_NewPC,
    input  logic             Head2_IsStore,
    input  logic             SB_Commit_Ready,
    output logic             Retire1_En,
    output logic             Retire2_En,
    output logic             SB_Commit_V,
    output logic             Flush,
    output logic             Redirect_V,
    output logic [PC_W-1:0]  Redirect_PC,
    output logic             Dispatch_Stall,
    output logic [CNT_W-1:0] Retired_Count
);

    localparam int unsigned RC_W = $clog2(RECOVER_CYCLES + 1);
    localparam logic [RC_W-1:0] RcInit = RC_W'(RECOVER_CYCLES);

    state_e           state_q, state_d;
    logic [RC_W-1:0]  rc_q, rc_d;
    logic             flush_q, flush_d;
    logic             redir_v_q, redir_v_d;
    logic [PC_W-1:0]  redir_pc_q, redir_pc_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             run;
    logic             mispred;
    logic [PC_W-1:0]  target;

    // Gating with RST keeps the grant outputs low for the whole reset pulse
    assign run = (state_q == StRun) & ~RST;

    rob_retire_select #(
        .PC_W(PC_W)
    ) u_select (
        .run_i       (run),
        .h1_v_i      (Head1_V),
        .h1_done_i   (Head1_Done),
        .h1_mispred_i(Head1_Mispred),
        .h1_new_pc_i (Head1_NewPC),
        .h1_store_i  (Head1_IsStore),
        .h2_v_i      (Head2_V),
        .h2_done_i   (Head2_Done),
        .h2_mispred_i(Head2_Mispred),
        .h2_new_pc_i (Head2_NewPC),
        .h2_store_i  (Head2_IsStore),
        .sb_ready_i  (SB_Commit_Ready),
        .retire1_o   (Retire1_En),
        .retire2_o   (Retire2_En),
        .sb_commit_o (SB_Commit_V),
        .mispred_o   (mispred),
        .target_o    (target)
    );

    always_comb begin
        state_d    = state_q;
        rc_d       = rc_q;
        flush_d    = 1'b0;
        redir_v_d  = 1'b0;
        redir_pc_d = redir_pc_q;
        stall_d    = stall_q;
        cnt_d      = cnt_q + CNT_W'(Retire1_En) + CNT_W'(Retire2_En);
        unique case (state_q)
            StRun: begin
                if (mispred) begin
                    state_d    = StFlush;
                    flush_d    = 1'b1;
                    redir_v_d  = 1'b1;
                    redir_pc_d = target;
                    stall_d    = 1'b1;
                end
            end
            StFlush: begin
                state_d = StRecover;
                rc_d    = RcInit;
                stall_d = 1'b1;
            end
            StRecover: begin
                rc_d = rc_q - RC_W'(1);
                if (rc_q == RC_W'(1)) begin
                    state_d = StRun;
                    stall_d = 1'b0;
                end
            end
            default: begin
                state_d = StRun;
                stall_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= StRun;
            rc_q       <= '0;
            flush_q    <= 1'b0;
            redir_v_q  <= 1'b0;
            redir_pc_q <= '0;
            stall_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rc_q       <= rc_d;
            flush_q    <= flush_d;
            redir_v_q  <= redir_v_d;
            redir_pc_q <= redir_pc_d;
            stall_q    <= stall_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Flush          = flush_q;
    assign Redirect_V     = redir_v_q;
    assign Redirect_PC    = redir_pc_q;
    assign Dispatch_Stall = stall_q;
    assign Retired_Count  = cnt_q;

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed plan steps plus random traffic against an in-order
// retirement model with a stall-cycle budget for mispredict recovery.
module tb_rob_commit_ctrl;

    localparam int unsigned PC_W = 16;
    localparam int unsigned RC   = 2;
    localparam int unsigned CW   = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            hv[2], hd[2], hm[2], hs[2];
    logic [PC_W-1:0] hpc[2];
    logic            sb_rdy;

    logic            r1, r2, sbv, flush, rv, stall;
    logic [PC_W-1:0] rpc;
    logic [CW-1:0]   cnt;

    int checks = 0;
    int failures = 0;

    // Reference state
    int              stall_left;
    logic            e_flush, e_rv, e_stall;
    logic [PC_W-1:0] e_rpc;
    logic [CW-1:0]   e_cnt;

    always #5 CLK = ~CLK;

    rob_commit_ctrl #(
        .PC_W          (PC_W),
        .RECOVER_CYCLES(RC),
        .CNT_W         (CW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Head1_V        (hv[0]),
        .Head1_Done     (hd[0]),
        .Head1_Mispred  (hm[0]),
        .Head1_NewPC    (hpc[0]),
        .Head1_IsStore  (hs[0]),
        .Head2_V        (hv[1]),
        .Head2_Done     (hd[1]),
        .Head2_Mispred  (hm[1]),
        .Head2_NewPC    (hpc[1]),
        .Head2_IsStore  (hs[1]),
        .SB_Commit_Ready(sb_rdy),
        .Retire1_En     (r1),
        .Retire2_En     (r2),
        .SB_Commit_V    (sbv),
        .Flush          (flush),
        .Redirect_V     (rv),
        .Redirect_PC    (rpc),
        .Dispatch_Stall (stall),
        .Retired_Count  (cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk the heads oldest-first; stop at the first entry that cannot go.
    function automatic int model_n();
        int n = 0;
        bit store_used = 0;
        for (int i = 0; i < 2; i++) begin
            if (!(hv[i] && hd[i])) break;
            if (hs[i] && (store_used || !sb_rdy)) break;
            n++;
            if (hs[i]) store_used = 1;
            if (hm[i]) break;
        end
        return n;
    endfunction

    task automatic model_reset();
        stall_left = 0;
        e_flush = 0; e_rv = 0; e_stall = 0; e_rpc = '0; e_cnt = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_flush"}, 32'(flush), 32'(e_flush));
        chk({tag, "_redir_v"}, 32'(rv), 32'(e_rv));
        chk({tag, "_redir_pc"}, 32'(rpc), 32'(e_rpc));
        chk({tag, "_stall"}, 32'(stall), 32'(e_stall));
        chk({tag, "_count"}, 32'(cnt), 32'(e_cnt));
    endtask

    task automatic set_heads(input logic v1, d1, m1, s1, input logic [PC_W-1:0] p1,
                             input logic v2, d2, m2, s2, input logic [PC_W-1:0] p2,
                             input logic rdy);
        hv[0] = v1; hd[0] = d1; hm[0] = m1; hs[0] = s1; hpc[0] = p1;
        hv[1] = v2; hd[1] = d2; hm[1] = m2; hs[1] = s2; hpc[1] = p2;
        sb_rdy = rdy;
    endtask

    // One clock: check grants mid-cycle, advance the model, check registers after the edge.
    task automatic cycle(input string tag);
        int n;
        bit m;
        logic [PC_W-1:0] tgt;
        bit e_sbv;
        @(negedge CLK);
        n = (stall_left == 0) ? model_n() : 0;
        e_sbv = (n >= 1 && hs[0]) || (n >= 2 && hs[1]);
        m = (n > 0) && hm[n-1];
        tgt = (n > 0) ? hpc[n-1] : '0;
        chk({tag, "_r1"}, 32'(r1), 32'(n >= 1));
        chk({tag, "_r2"}, 32'(r2), 32'(n >= 2));
        chk({tag, "_sbv"}, 32'(sbv), 32'(e_sbv));
        @(posedge CLK);
        #1;
        e_cnt = e_cnt + CW'(n);
        e_flush = 0;
        e_rv = 0;
        if (stall_left == 0 && m) begin
            e_flush = 1; e_rv = 1; e_rpc = tgt; e_stall = 1;
            stall_left = 1 + RC;
        end else if (stall_left > 0) begin
            stall_left--;
            e_stall = (stall_left > 0);
        end
        check_regs(tag);
    endtask

    initial begin
        set_heads(0, 0, 0, 0, '0, 0, 0, 0, 0, '0, 0);
        model_reset();
        #1;
        check_regs("reset");
        chk("reset_r1", 32'(r1), 32'd0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 1'b0;

        // Both heads done, plain ops
        set_heads(1, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 1);
        cycle("dual");
        chk("dual_count2", 32'(cnt), 32'd2);

        // Two stores: only one commits, the second retires next cycle from slot 1
        set_heads(1, 1, 0, 1, 16'h0, 1, 1, 0, 1, 16'h0, 1);
        cycle("two_st");
        set_heads(1, 1, 0, 1, 16'h0, 0, 0, 0, 0, 16'h0, 1);
        cycle("st_next");

        // Store blocked by the store buffer
        set_heads(1, 1, 0, 1, 16'h0, 1, 1, 0, 0, 16'h0, 0);
        cycle("st_block");

        // Slot 2 valid with slot 1 empty
        set_heads(0, 0, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 1);
        cycle("h1_empty");

        // Slot 1 mispredict, then flush and recovery
        set_heads(1, 1, 1, 0, 16'h0040, 1, 1, 0, 0, 16'h9999, 1);
        cycle("mp1");
        chk("mp1_pc", 32'(rpc), 32'h0040);
        set_heads(1, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 1);
        for (int i = 0; i < 4; i++) cycle("mp1_rec");
        chk("mp1_resume_stall", 32'(stall), 32'd0);

        // Slot 2 mispredict with slot 1 clean
        set_heads(1, 1, 0, 0, 16'h7777, 1, 1, 1, 0, 16'h1234, 1);
        cycle("mp2");
        chk("mp2_pc", 32'(rpc), 32'h1234);
        set_heads(1, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 1);
        cycle("mp2_flush");

        // Reset pulse mid-RECOVER
        @(negedge CLK);
        #1;
        RST = 1'b1;
        #1;
        model_reset();
        check_regs("rst_mid");
        chk("rst_mid_r1", 32'(r1), 32'd0);
        chk("rst_mid_r2", 32'(r2), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;
        cycle("post_rst");
        chk("post_rst_cnt", 32'(cnt), 32'd2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 2; k++) begin
                hv[k] = ($urandom_range(0, 7) != 0);
                hd[k] = ($urandom_range(0, 3) != 0);
                hm[k] = ($urandom_range(0, 11) == 0);
                hs[k] = ($urandom_range(0, 3) == 0);
                hpc[k] = PC_W'($urandom);
            end
            sb_rdy = ($urandom_range(0, 2) != 0);
            cycle("rand");
        end

        // Drive the counter up to the wrap point
        set_heads(1, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 1);
        while (stall_left != 0) cycle("drain");
        while (e_cnt < 16'hFFFD) cycle("fill");
        set_heads(1, 1, 0, 0, 16'h0, 0, 0, 0, 0, 16'h0, 1);
        while (e_cnt != 16'hFFFF) cycle("fill1");
        chk("pre_wrap", 32'(cnt), 32'hFFFF);
        set_heads(1, 1, 0, 0, 16'h0, 1, 1, 0, 0, 16'h0, 1);
        cycle("wrap");
        chk("wrap_val", 32'(cnt), 32'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob_commit_ctrl.md
Name: rob_commit_ctrl

Overview:
- Sequences in-order commit at the ROB head.
- Examines the two oldest ROB entries each cycle and grants up to two retirements.
- Serialises store commits against store-buffer readiness.
- On retirement of a mispredicted branch, runs a flush/redirect/recovery sequence that squashes younger state and stalls dispatch until the pipeline is clean.

Parameters:
PC_W, 16, program counter width
RECOVER_CYCLES, 2, dispatch-stall cycles after the flush cycle (must be >=1)
CNT_W, 16, width of the retired-instruction counter

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous, active-high
Head1_V  in  1  oldest ROB entry busy
Head1_Done  in  1  oldest entry has executed
Head1_Mispred  in  1  oldest entry is a mispredicted branch
Head1_NewPC  in  PC_W  correct target for oldest entry
Head1_IsStore  in  1  oldest entry is a store
Head2_V  in  1  second-oldest entry busy
Head2_Done  in  1  second-oldest entry has executed
Head2_Mispred  in  1  second-oldest entry is a mispredicted branch
Head2_NewPC  in  PC_W  correct target for second-oldest entry
Head2_IsStore  in  1  second-oldest entry is a store
SB_Commit_Ready  in  1  store buffer accepts one store commit this cycle
Retire1_En  out  1  retire oldest entry this cycle (combinational)
Retire2_En  out  1  retire second-oldest entry this cycle (combinational)
SB_Commit_V  out  1  one store commits this cycle (combinational)
Flush  out  1  squash all in-flight state (registered)
Redirect_V  out  1  fetch redirect valid (registered)
Redirect_PC  out  PC_W  fetch redirect target (registered)
Dispatch_Stall  out  1  block dispatch (registered)
Retired_Count  out  CNT_W  total instructions retired (registered, wraps)

Behaviour:
- FSM states: RUN, FLUSH, RECOVER. A down-counter rc of width clog2(RECOVER_CYCLES+1) runs during RECOVER.
- Reset (asynchronous): state=RUN, rc=0, Flush=0, Redirect_V=0, Redirect_PC=0, Dispatch_Stall=0, Retired_Count=0. Combinational outputs are 0 while RST is high.
- Assertion of RST mid-FLUSH or mid-RECOVER aborts the sequence and returns to RUN.
- ok1 = Head1_V & Head1_Done & (~Head1_IsStore | SB_Commit_Ready).
- Retire1_En = (state==RUN) & ok1.
- Retire2_En = Retire1_En & ~Head1_Mispred & Head2_V & Head2_Done & ~(Head1_IsStore & Head2_IsStore) & (~Head2_IsStore | SB_Commit_Ready).
- Retirement is strictly in order: slot 2 never retires without slot 1. At most one store commits per cycle.
- SB_Commit_V = (Retire1_En & Head1_IsStore) | (Retire2_En & Head2_IsStore).
- Mispredict detection uses the youngest retiring entry: m = (Retire2_En & Head2_Mispred) | (Retire1_En & Head1_Mispred). Target = Head1_NewPC if slot 1 is the mispredicted one, else Head2_NewPC.
- RUN with m=1: the mispredicted branch itself retires this cycle. Next edge: state=FLUSH, Flush=1, Redirect_V=1, Redirect_PC=target, Dispatch_Stall=1.
- FLUSH always lasts exactly one cycle. Next edge: state=RECOVER, Flush=0, Redirect_V=0, rc=RECOVER_CYCLES, Dispatch_Stall stays 1.
- Redirect_PC holds its value until the next mispredict.
- RECOVER: rc decrements each cycle. On the edge where rc==1, state=RUN and Dispatch_Stall=0.
- Net effect: Dispatch_Stall is high for 1+RECOVER_CYCLES cycles.
- No retirement occurs in FLUSH or RECOVER. Head inputs are ignored there.
- Retired_Count += Retire1_En + Retire2_En each edge, modulo 2^CNT_W; wrap-around is silent.
- Head2_V=1 with Head1_V=0 is treated as empty: nothing retires.

Decomposition:
- Shared package (rob_pkg): PC_W, state encoding (RUN=2'd0, FLUSH=2'd1, RECOVER=2'd2), and the ROB entry field offsets already used by the ROB.
- Natural sub-module: rob_retire_select, the purely combinational grant logic for Retire1_En, Retire2_En, SB_Commit_V, m and target.
- The FSM and counters stay in the top module.

Test Plan:
- Both heads done, non-store, no mispredict -> Retire1_En=Retire2_En=1 the same cycle; Retired_Count 0->2.
- Head1 and Head2 both stores, SB_Commit_Ready=1 -> only Retire1_En=1, SB_Commit_V=1; next cycle Head2 at slot 1 retires.
- Head1 store with SB_Commit_Ready=0 -> Retire1_En=Retire2_En=0 even though Head2 is done.
- Head1 done, Head1_Mispred=1, Head1_NewPC=16'h0040, Head2 done -> only Retire1_En=1. Next cycle Flush=1, Redirect_V=1, Redirect_PC=16'h0040. Dispatch_Stall=1 for 3 cycles (RECOVER_CYCLES=2), then RUN resumes retiring.
- Head2 mispredicts with target 16'h1234 while Head1 is clean -> both retire; the flush cycle follows with Redirect_PC=16'h1234.
- RST pulsed during RECOVER -> all registered outputs 0 immediately; with heads done and RST released, retirement proceeds the next cycle. Separately, a counter preset near 2^16-1 wraps to 0/1 correctly.
